// File: rtl/pwm_update_seq.sv
// Atomic PWM reprogramming sequencer: disables the counter, writes PERIOD/COMPARE1/COMPARE2
// byte-wise, optionally resets the counter, restores enable, and owns the register-file port.
module pwm_update_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        restart,
  input  logic [15:0] new_period,
  input  logic [15:0] new_cmp1,
  input  logic [15:0] new_cmp2,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  input  logic        dcd_read,
  input  logic        dcd_write,
  input  logic [5:0]  dcd_addr,
  input  logic [7:0]  dcd_data_write,
  output logic        dcd_wait,
  output logic        reg_read,
  output logic        reg_write,
  output logic [5:0]  reg_addr,
  output logic [7:0]  reg_data_write,
  input  logic [7:0]  reg_data_read
);

  typedef enum logic [3:0] {
    IDLE, RD_EN, W_DIS, W_PL, W_PM, W_C1L, W_C1M, W_C2L, W_C2M, W_RST, W_EN, DONE
  } state_t;

  state_t      state_q;
  logic        restart_q;
  logic [15:0] period_q;
  logic [15:0] cmp1_q;
  logic [15:0] cmp2_q;
  logic        en_saved_q;
  logic        pend_q;
  logic        pend_wr_q;
  logic [5:0]  pend_addr_q;
  logic [7:0]  pend_data_q;

  logic dcd_acc;
  logic in_upd;

  assign dcd_acc  = dcd_read | dcd_write;
  assign in_upd   = (state_q != IDLE) && (state_q != DONE);
  assign busy     = in_upd;
  assign done     = (state_q == DONE);
  assign dcd_wait = pend_q;
  // A held access blocks any further decoder access until the DONE cycle has retired it.
  assign overrun  = dcd_acc && pend_q && (in_upd || (state_q == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      restart_q   <= 1'b0;
      period_q    <= '0;
      cmp1_q      <= '0;
      cmp2_q      <= '0;
      en_saved_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            restart_q <= restart;
            period_q  <= new_period;
            cmp1_q    <= new_cmp1;
            cmp2_q    <= new_cmp2;
            state_q   <= RD_EN;
          end
        end
        RD_EN: state_q <= W_DIS;
        W_DIS: begin
          en_saved_q <= reg_data_read[0];
          state_q    <= W_PL;
        end
        W_PL:  state_q <= W_PM;
        W_PM:  state_q <= W_C1L;
        W_C1L: state_q <= W_C1M;
        W_C1M: state_q <= W_C2L;
        W_C2L: state_q <= W_C2M;
        W_C2M: state_q <= restart_q ? W_RST : W_EN;
        W_RST: state_q <= W_EN;
        W_EN:  state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (in_upd && dcd_acc && !pend_q) begin
        pend_q      <= 1'b1;
        pend_wr_q   <= dcd_write;
        pend_addr_q <= dcd_addr;
        pend_data_q <= dcd_data_write;
      end else if (state_q == DONE) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Single register-file port: decoder pass-through unless the sequencer or a held access owns it.
  always_comb begin
    reg_read       = dcd_read;
    reg_write      = dcd_write;
    reg_addr       = dcd_addr;
    reg_data_write = dcd_data_write;
    if (in_upd) begin
      reg_read       = 1'b0;
      reg_write      = 1'b1;
      reg_addr       = 6'h00;
      reg_data_write = 8'h00;
      case (state_q)
        RD_EN: begin
          reg_read  = 1'b1;
          reg_write = 1'b0;
          reg_addr  = 6'h02;
        end
        W_DIS: reg_addr = 6'h02;
        W_PL: begin
          reg_addr       = 6'h00;
          reg_data_write = period_q[7:0];
        end
        W_PM: begin
          reg_addr       = 6'h01;
          reg_data_write = period_q[15:8];
        end
        W_C1L: begin
          reg_addr       = 6'h03;
          reg_data_write = cmp1_q[7:0];
        end
        W_C1M: begin
          reg_addr       = 6'h04;
          reg_data_write = cmp1_q[15:8];
        end
        W_C2L: begin
          reg_addr       = 6'h05;
          reg_data_write = cmp2_q[7:0];
        end
        W_C2M: begin
          reg_addr       = 6'h06;
          reg_data_write = cmp2_q[15:8];
        end
        W_RST: reg_addr = 6'h07;
        W_EN: begin
          reg_addr       = 6'h02;
          reg_data_write = {7'b0, en_saved_q};
        end
        default: begin
          reg_write = 1'b0;
        end
      endcase
    end else if ((state_q == DONE) && pend_q) begin
      reg_read       = ~pend_wr_q;
      reg_write      = pend_wr_q;
      reg_addr       = pend_addr_q;
      reg_data_write = pend_data_q;
    end
  end

endmodule

// File: tb/tb_pwm_update_seq.sv
// Scoreboard bench for pwm_update_seq: stimulus pushes expected bus/done/overrun events,
// a negedge monitor pops and compares every event the DUT presents.
module tb_pwm_update_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, restart;
  logic [15:0] new_period, new_cmp1, new_cmp2;
  logic        busy, done, overrun;
  logic        dcd_read, dcd_write;
  logic [5:0]  dcd_addr;
  logic [7:0]  dcd_data_write;
  logic        dcd_wait;
  logic        reg_read, reg_write;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data_write;
  logic [7:0]  rdata;
  logic [7:0]  mem [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_OVR = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [5:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t q[$];

  pwm_update_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .restart(restart),
    .new_period(new_period), .new_cmp1(new_cmp1), .new_cmp2(new_cmp2),
    .busy(busy), .done(done), .overrun(overrun),
    .dcd_read(dcd_read), .dcd_write(dcd_write), .dcd_addr(dcd_addr),
    .dcd_data_write(dcd_data_write), .dcd_wait(dcd_wait),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_data_write(reg_data_write), .reg_data_read(rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: write on reg_write, read data valid the cycle after reg_read.
  always @(posedge clk) begin
    if (reg_write) mem[reg_addr] <= reg_data_write;
    if (reg_read) rdata <= mem[reg_addr];
  end

  task automatic expect_ev(input int c, input int kind, input logic [5:0] a, input logic [7:0] d);
    ev_t e;
    int i;
    e.cyc = c; e.kind = kind; e.addr = a; e.data = d;
    i = 0;
    while (i < q.size() && (q[i].cyc < c || (q[i].cyc == c && q[i].kind <= kind))) i++;
    q.insert(i, e);
  endtask

  task automatic see_ev(input int kind, input logic [5:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event cyc=%0d kind=%0d addr=%h data=%h required=none", cyc, kind, a, d);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL event got cyc=%0d kind=%0d addr=%h data=%h required cyc=%0d kind=%0d addr=%h data=%h",
                 cyc, kind, a, d, e.cyc, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reg_read)  see_ev(K_RD, reg_addr, 8'h00);
    if (reg_write) see_ev(K_WR, reg_addr, reg_data_write);
    if (done)      see_ev(K_DONE, 6'h00, 8'h00);
    if (overrun)   see_ev(K_OVR, 6'h00, 8'h00);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    start = 1'b0; restart = 1'b0;
    dcd_read = 1'b0; dcd_write = 1'b0; dcd_addr = '0; dcd_data_write = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    start = 1'b0; restart = 1'b0;
    new_period = '0; new_cmp1 = '0; new_cmp2 = '0;
    dcd_read = 1'b0; dcd_write = 1'b0; dcd_addr = '0; dcd_data_write = '0;
    repeat (3) next();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_dcd_wait", dcd_wait, 0);
    rst_n = 1'b1;
    next();

    // Idle pass-through: set EN=1, then read 0x08.
    next(); dcd_write = 1'b1; dcd_addr = 6'h02; dcd_data_write = 8'h01;
    expect_ev(cyc, K_WR, 6'h02, 8'h01);
    next(); dcd_read = 1'b1; dcd_addr = 6'h08;
    expect_ev(cyc, K_RD, 6'h08, 8'h00);
    next();

    // Update, restart=0, EN=1, deferred write, overrun, ignored starts.
    next(); t = cyc;
    start = 1'b1; restart = 1'b0;
    new_period = 16'h1234; new_cmp1 = 16'h0056; new_cmp2 = 16'h0789;
    chk("t1_busy_T", busy, 0);
    expect_ev(t + 1, K_RD, 6'h02, 8'h00);
    expect_ev(t + 2, K_WR, 6'h02, 8'h00);
    expect_ev(t + 3, K_WR, 6'h00, 8'h34);
    expect_ev(t + 4, K_WR, 6'h01, 8'h12);
    expect_ev(t + 5, K_WR, 6'h03, 8'h56);
    expect_ev(t + 6, K_WR, 6'h04, 8'h00);
    expect_ev(t + 7, K_WR, 6'h05, 8'h89);
    expect_ev(t + 8, K_WR, 6'h06, 8'h07);
    expect_ev(t + 9, K_WR, 6'h02, 8'h01);
    expect_ev(t + 10, K_DONE, 6'h00, 8'h00);
    expect_ev(t + 10, K_WR, 6'h0A, 8'h05);
    expect_ev(t + 6, K_OVR, 6'h00, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      next();
      new_period = 16'hFFFF; new_cmp1 = 16'hFFFF; new_cmp2 = 16'hFFFF;
      case (k)
        1: chk("t1_busy_T1", busy, 1);
        3: start = 1'b1;
        4: begin
          chk("t1_wait_T4", dcd_wait, 0);
          dcd_write = 1'b1; dcd_addr = 6'h0A; dcd_data_write = 8'h05;
        end
        5: chk("t1_wait_T5", dcd_wait, 1);
        6: begin dcd_read = 1'b1; dcd_addr = 6'h0B; end
        9: chk("t1_busy_T9", busy, 1);
        10: begin
          chk("t1_wait_T10", dcd_wait, 1);
          chk("t1_busy_T10", busy, 0);
          start = 1'b1; restart = 1'b1;
        end
        11: begin
          chk("t1_wait_T11", dcd_wait, 0);
          chk("t1_busy_T11", busy, 0);
        end
        default: ;
      endcase
    end

    // Update, restart=1, EN=0, deferred read, overrun in DONE.
    next(); dcd_write = 1'b1; dcd_addr = 6'h02; dcd_data_write = 8'h00;
    expect_ev(cyc, K_WR, 6'h02, 8'h00);
    next(); t = cyc;
    start = 1'b1; restart = 1'b1;
    new_period = 16'hA5C3; new_cmp1 = 16'hFFFF; new_cmp2 = 16'h0000;
    expect_ev(t + 1, K_RD, 6'h02, 8'h00);
    expect_ev(t + 2, K_WR, 6'h02, 8'h00);
    expect_ev(t + 3, K_WR, 6'h00, 8'hC3);
    expect_ev(t + 4, K_WR, 6'h01, 8'hA5);
    expect_ev(t + 5, K_WR, 6'h03, 8'hFF);
    expect_ev(t + 6, K_WR, 6'h04, 8'hFF);
    expect_ev(t + 7, K_WR, 6'h05, 8'h00);
    expect_ev(t + 8, K_WR, 6'h06, 8'h00);
    expect_ev(t + 9, K_WR, 6'h07, 8'h00);
    expect_ev(t + 10, K_WR, 6'h02, 8'h00);
    expect_ev(t + 11, K_RD, 6'h00, 8'h00);
    expect_ev(t + 11, K_DONE, 6'h00, 8'h00);
    expect_ev(t + 11, K_OVR, 6'h00, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      next();
      case (k)
        3: begin dcd_read = 1'b1; dcd_addr = 6'h00; end
        10: chk("t2_busy_T10", busy, 1);
        11: begin
          chk("t2_wait_T11", dcd_wait, 1);
          dcd_write = 1'b1; dcd_addr = 6'h0C; dcd_data_write = 8'h77;
        end
        12: begin
          chk("t2_wait_T12", dcd_wait, 0);
          chk("t2_deferred_rdata", rdata, 8'hC3);
        end
        default: ;
      endcase
    end

    // Reset asserted mid-update at T+5 with a held access.
    next(); t = cyc;
    start = 1'b1; restart = 1'b1;
    new_period = 16'h0F0E; new_cmp1 = 16'h1111; new_cmp2 = 16'h2222;
    expect_ev(t + 1, K_RD, 6'h02, 8'h00);
    expect_ev(t + 2, K_WR, 6'h02, 8'h00);
    expect_ev(t + 3, K_WR, 6'h00, 8'h0E);
    expect_ev(t + 4, K_WR, 6'h01, 8'h0F);
    for (int k = 1; k <= 5; k++) begin
      next();
      if (k == 4) begin dcd_write = 1'b1; dcd_addr = 6'h0D; dcd_data_write = 8'h3C; end
      if (k == 5) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wait", dcd_wait, 0);
        chk("rst_mid_done", done, 0);
      end
    end
    next(); next();
    rst_n = 1'b1;
    repeat (14) next();
    chk("post_rst_wait", dcd_wait, 0);
    dcd_read = 1'b1; dcd_addr = 6'h08;
    expect_ev(cyc, K_RD, 6'h08, 8'h00);
    repeat (3) next();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d required=0 first_cyc=%0d kind=%0d", q.size(), q[0].cyc, q[0].kind);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_update_seq.md
# pwm_update_seq

Atomic reprogramming sequencer for the PWM register file. On a single start pulse it captures new PERIOD, COMPARE1 and COMPARE2 values and writes them byte by byte over the register bus. During the update the counter is disabled, an optional counter reset is issued, and the original counter-enable state is restored afterwards. It sits between the instruction decoder and the register file and owns that file's single read/write port: it forwards decoder accesses while idle and defers one decoder access while an update is running.

## Interface
Parameters: none. Register map is fixed: 0x00/0x01 PERIOD, 0x02 COUNTER_EN, 0x03/0x04 COMPARE1, 0x05/0x06 COMPARE2, 0x07 COUNTER_RESET.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin an update
- restart  in  1  sampled with start; 1 = include a COUNTER_RESET write
- new_period  in  16  PERIOD value, sampled with start
- new_cmp1  in  16  COMPARE1 value, sampled with start
- new_cmp2  in  16  COMPARE2 value, sampled with start
- busy  out  1  update in progress
- done  out  1  one-cycle pulse when the update completes
- overrun  out  1  one-cycle pulse when a decoder access is dropped
- dcd_read  in  1  decoder read pulse
- dcd_write  in  1  decoder write pulse
- dcd_addr  in  6  decoder address
- dcd_data_write  in  8  decoder write data
- dcd_wait  out  1  a decoder access is held pending
- reg_read  out  1  register-file read pulse
- reg_write  out  1  register-file write pulse
- reg_addr  out  6  register-file address
- reg_data_write  out  8  register-file write data
- reg_data_read  in  8  register-file read data, valid the cycle after reg_read

## Operation
States: IDLE, RD_EN, W_DIS, W_PL, W_PM, W_C1L, W_C1M, W_C2L, W_C2M, W_RST, W_EN, DONE.

- **IDLE**
  - reg_* mirror dcd_* combinationally.
  - start captures restart, new_period, new_cmp1 and new_cmp2, then moves to RD_EN.
- **RD_EN:** read at address 0x02.
- **W_DIS:** en_saved <= reg_data_read[0]; write 0x00 to 0x02.
- **W_PL, W_PM:** write new_period[7:0] to 0x00, then new_period[15:8] to 0x01.
- **W_C1L, W_C1M:** write new_cmp1 LSB to 0x03, then MSB to 0x04.
- **W_C2L, W_C2M:** write new_cmp2 LSB to 0x05, then MSB to 0x06.
- **W_RST:** entered only if restart was captured as 1; write 0x00 to 0x07.
- **W_EN:** write {7'b0, en_saved} to 0x02.
- **DONE**
  - done=1.
  - If a pending access exists, it is driven on reg_*. Otherwise dcd_* pass through.
  - Next state is IDLE.

Busy and held accesses:
- busy=1 in every state from RD_EN through W_EN. It is 0 in IDLE and DONE.
- start while busy=1 or in DONE is ignored: no capture, no effect.
- Any decoder access while busy=1 is never forwarded.
  - With no access pending, it is latched (read/write, addr, data) into a one-entry buffer, and dcd_wait=1 from the next cycle.
  - With an access already pending, it is dropped and overrun pulses in the same cycle.
- While dcd_wait=1, a decoder access in the DONE cycle is also dropped with an overrun pulse.
- The pending entry is issued in DONE and cleared at the end of DONE.
- Only one reg_read/reg_write pulse is issued per cycle.

## Timing
- Reset values:
  - State IDLE; busy=0, done=0, overrun=0, dcd_wait=0.
  - Pending buffer empty; en_saved=0; captured values 0.
  - reg_* follow dcd_* combinationally in IDLE.
- start accepted in cycle T: RD_EN at T+1, W_DIS at T+2, W_PL at T+3, then one state per cycle.
- restart=1: W_RST at T+9, W_EN at T+10, DONE at T+11. Total 11 cycles from start to done.
- restart=0: W_EN at T+9, DONE at T+10.
- The write in W_DIS and the capture of en_saved occur in the same cycle. This is legal because the read data is already valid.
- Deferred read: its reg_data_read is valid in the first cycle after DONE, which is also the first cycle with dcd_wait=0.
- Reset asserted mid-update: abort immediately to reset values. No further bus pulses, no done, pending access discarded.

## Test plan
- **Basic update, restart=0:** start with new_period=0x1234, new_cmp1=0x0056, new_cmp2=0x0789, register EN=1 → writes issued exactly at cycles T+2..T+9:
  - (0x02,0x00), (0x00,0x34), (0x01,0x12), (0x03,0x56), (0x04,0x00), (0x05,0x89), (0x06,0x07), (0x02,0x01)
  - done at T+10.
- **Restart=1 with EN=0:** write (0x07,0x00) at T+9, final write (0x02,0x00) at T+10, done at T+11.
- **Deferred decoder access:** decoder write (0x0A,0x05) at T+4 → not forwarded; dcd_wait=1 from T+5 to T+10; issued in the DONE cycle (T+10 with restart=0).
- **Second access while one is pending:** a further decoder access at T+6 → overrun pulse at T+6, access never reaches reg_*.
- **Idle pass-through:** decoder read (0x08) while idle → reg_read same cycle; start during busy → ignored, single done.
- **Reset at T+5:** assert rst_n low → all outputs return to reset values next edge-free cycle, no done pulse.
